// File: rtl/lock_pkg.sv
// ============================================================================
// Module : lock_pkg
// Brief  : State codes, button codes and digit count shared by the lock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lock_pkg;

    localparam int DIGITS = 4;

    typedef enum logic [2:0] {
        ST_ENTER    = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_SET      = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_e;

    // Values match the button stage that produces WHICH_BTN_POSEDGE.
    typedef enum logic [1:0] {
        BTN_RESET     = 2'd0,
        BTN_ADMIN     = 2'd1,
        BTN_OK        = 2'd2,
        BTN_BACKSPACE = 2'd3
    } btn_e;

endpackage

`default_nettype wire

// File: rtl/pwd_entry_buf.sv
// ============================================================================
// Module : pwd_entry_buf
// Brief  : Digit shift/backspace buffer with its occupancy count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pwd_entry_buf
    import lock_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  shift_i,
    input  logic                  back_i,
    input  logic [3:0]            digit_i,
    output logic [4*DIGITS-1:0]   entry_o,
    output logic [2:0]            cnt_o
);

    localparam logic [2:0] C_FULL = 3'(DIGITS);

    logic [4*DIGITS-1:0] entry_q, entry_d;
    logic [2:0]          cnt_q, cnt_d;

    // Clear outranks shift, shift outranks backspace.
    always_comb begin
        entry_d = entry_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            entry_d = '0;
            cnt_d   = 3'd0;
        end else if (shift_i && (cnt_q < C_FULL)) begin
            entry_d = {entry_q[4*DIGITS-5:0], digit_i};
            cnt_d   = cnt_q + 3'd1;
        end else if (back_i && (cnt_q != 3'd0)) begin
            entry_d = entry_q >> 4;
            cnt_d   = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q <= '0;
            cnt_q   <= 3'd0;
        end else begin
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign entry_o = entry_q;
    assign cnt_o   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/password_lock_fsm.sv
// ============================================================================
// Module : password_lock_fsm
// Brief  : Keypad lock FSM with password change, auto-relock and lockout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module password_lock_fsm #(
    parameter int                  DIGITS        = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_PWD   = 16'h1234,
    parameter int                  MAX_ERR       = 3,
    parameter logic [31:0]         UNLOCK_CYCLES = 32'd500_000_000,
    parameter logic [31:0]         LOCK_CYCLES   = 32'd1_000_000_000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  BTN_CHANGE_FLAG,
    input  logic [1:0]            WHICH_BTN_POSEDGE,
    input  logic [3:0]            SW_DIGIT,
    output logic                  UNLOCK,
    output logic                  ALARM,
    output logic [2:0]            STATE,
    output logic [2:0]            DIGIT_CNT,
    output logic [4*DIGITS-1:0]   ENTRY,
    output logic [1:0]            ERR_CNT
);
    import lock_pkg::*;

    localparam logic [2:0] C_LAST    = 3'(DIGITS - 1);
    localparam logic [2:0] C_MAX_ERR = 3'(MAX_ERR);

    state_e              state_q, state_d;
    logic [1:0]          err_q, err_d;
    logic [31:0]         timer_q, timer_d;
    logic [4*DIGITS-1:0] pwd_q, pwd_d;

    logic                w_clear, w_shift, w_back;
    logic                w_ev;
    btn_e                w_btn;
    logic [2:0]          w_err_inc;

    assign w_ev      = BTN_CHANGE_FLAG;
    assign w_btn     = btn_e'(WHICH_BTN_POSEDGE);
    assign w_err_inc = {1'b0, err_q} + 3'd1;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        timer_d = timer_q;
        pwd_d   = pwd_q;
        w_clear = 1'b0;
        w_shift = 1'b0;
        w_back  = 1'b0;
        case (state_q)
            ST_ENTER: begin
                if (w_ev) begin
                    case (w_btn)
                        BTN_OK: begin
                            w_shift = 1'b1;
                            if (DIGIT_CNT == C_LAST) state_d = ST_CHECK;
                        end
                        BTN_BACKSPACE: w_back  = 1'b1;
                        BTN_RESET:     w_clear = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_SET: begin
                if (w_ev) begin
                    case (w_btn)
                        BTN_OK: begin
                            if (DIGIT_CNT == C_LAST) begin
                                pwd_d   = {ENTRY[4*DIGITS-5:0], SW_DIGIT};
                                w_clear = 1'b1;
                                state_d = ST_ENTER;
                            end else begin
                                w_shift = 1'b1;
                            end
                        end
                        BTN_BACKSPACE: w_back = 1'b1;
                        BTN_RESET: begin
                            w_clear = 1'b1;
                            state_d = ST_ENTER;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CHECK: begin
                // Single-cycle verdict; events arriving now are dropped.
                w_clear = 1'b1;
                if (ENTRY == pwd_q) begin
                    err_d   = 2'd0;
                    timer_d = UNLOCK_CYCLES - 32'd1;
                    state_d = ST_UNLOCKED;
                end else if (w_err_inc >= C_MAX_ERR) begin
                    err_d   = 2'd0;
                    timer_d = LOCK_CYCLES - 32'd1;
                    state_d = ST_LOCKOUT;
                end else begin
                    err_d   = w_err_inc[1:0];
                    state_d = ST_ENTER;
                end
            end
            ST_UNLOCKED: begin
                // ADMIN/RESET events beat expiry; OK/BACKSPACE let the timer run.
                if (w_ev && (w_btn == BTN_ADMIN)) begin
                    w_clear = 1'b1;
                    timer_d = 32'd0;
                    state_d = ST_SET;
                end else if (w_ev && (w_btn == BTN_RESET)) begin
                    timer_d = 32'd0;
                    state_d = ST_ENTER;
                end else if (timer_q == 32'd0) begin
                    state_d = ST_ENTER;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == 32'd0) begin
                    state_d = ST_ENTER;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: begin
                timer_d = 32'd0;
                state_d = ST_ENTER;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_ENTER;
            err_q   <= 2'd0;
            timer_q <= 32'd0;
            pwd_q   <= DEFAULT_PWD;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            pwd_q   <= pwd_d;
        end
    end

    pwd_entry_buf u_entry_buf (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .clear_i (w_clear),
        .shift_i (w_shift),
        .back_i  (w_back),
        .digit_i (SW_DIGIT),
        .entry_o (ENTRY),
        .cnt_o   (DIGIT_CNT)
    );

    assign STATE   = state_q;
    assign ERR_CNT = err_q;
    assign UNLOCK  = (state_q == ST_UNLOCKED);
    assign ALARM   = (state_q == ST_LOCKOUT);

endmodule

`default_nettype wire

// File: tb/tb_password_lock_fsm.sv
// ============================================================================
// Module : tb_password_lock_fsm
// Brief  : Directed and random stimulus against a queue-based lock model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_password_lock_fsm;

    localparam int UNLOCK_N = 5;
    localparam int LOCK_N   = 8;
    localparam int MAXE     = 3;
    localparam int PWD0     = 'h1234;

    localparam logic [1:0] B_RST = 2'd0, B_ADM = 2'd1, B_OK = 2'd2, B_BS = 2'd3;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        BTN_CHANGE_FLAG = 1'b0;
    logic [1:0]  WHICH_BTN_POSEDGE = 2'd0;
    logic [3:0]  SW_DIGIT = 4'd0;
    logic        UNLOCK, ALARM;
    logic [2:0]  STATE, DIGIT_CNT;
    logic [15:0] ENTRY;
    logic [1:0]  ERR_CNT;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    password_lock_fsm #(
        .DIGITS        (4),
        .DEFAULT_PWD   (16'h1234),
        .MAX_ERR       (3),
        .UNLOCK_CYCLES (32'd5),
        .LOCK_CYCLES   (32'd8)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .BTN_CHANGE_FLAG   (BTN_CHANGE_FLAG),
        .WHICH_BTN_POSEDGE (WHICH_BTN_POSEDGE),
        .SW_DIGIT          (SW_DIGIT),
        .UNLOCK            (UNLOCK),
        .ALARM             (ALARM),
        .STATE             (STATE),
        .DIGIT_CNT         (DIGIT_CNT),
        .ENTRY             (ENTRY),
        .ERR_CNT           (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    // Model: mode 0 enter, 1 check, 2 unlocked, 3 set, 4 lockout.
    int m_st = 0;
    int m_q[$];
    int m_err = 0;
    int m_left = 0;
    int m_pwd = PWD0;

    function automatic int pack_q();
        int v = 0;
        foreach (m_q[i]) v = (v << 4) | m_q[i];
        return v;
    endfunction

    task automatic model_step();
        bit ev;
        int b, d;
        ev = BTN_CHANGE_FLAG;
        b  = int'(WHICH_BTN_POSEDGE);
        d  = int'(SW_DIGIT);
        if (RESET) begin
            m_st = 0; m_q.delete(); m_err = 0; m_left = 0; m_pwd = PWD0;
            return;
        end
        case (m_st)
            0, 3: if (ev) begin
                if (b == 2) begin
                    if (m_st == 3 && m_q.size() == 3) begin
                        m_pwd = ((pack_q() << 4) | d) & 'hFFFF;
                        m_q.delete();
                        m_st = 0;
                    end else if (m_q.size() < 4) begin
                        m_q.push_back(d);
                        if (m_st == 0 && m_q.size() == 4) m_st = 1;
                    end
                end else if (b == 3) begin
                    if (m_q.size() > 0) void'(m_q.pop_back());
                end else if (b == 0) begin
                    m_q.delete();
                    m_st = 0;
                end
            end
            1: begin
                if (pack_q() == m_pwd) begin
                    m_err = 0; m_left = UNLOCK_N; m_st = 2;
                end else if (m_err + 1 == MAXE) begin
                    m_err = 0; m_left = LOCK_N; m_st = 4;
                end else begin
                    m_err++; m_st = 0;
                end
                m_q.delete();
            end
            2: begin
                if (ev && b == 1) begin
                    m_q.delete(); m_st = 3;
                end else if (ev && b == 0) begin
                    m_st = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) m_st = 0;
                end
            end
            4: begin
                m_left--;
                if (m_left == 0) m_st = 0;
            end
            default: m_st = 0;
        endcase
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            checks++;
            if (STATE !== 3'(m_st) || DIGIT_CNT !== 3'(m_q.size()) ||
                ENTRY !== 16'(pack_q()) || ERR_CNT !== 2'(m_err) ||
                UNLOCK !== (m_st == 2) || ALARM !== (m_st == 4)) begin
                errors++;
                $display("FAIL cycle t=%0t: got st=%0d cnt=%0d entry=%h err=%0d un=%b al=%b; expected st=%0d cnt=%0d entry=%h err=%0d",
                         $time, STATE, DIGIT_CNT, ENTRY, ERR_CNT, UNLOCK, ALARM,
                         m_st, m_q.size(), pack_q(), m_err);
            end
        end
    end

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ev(input logic [1:0] b, input logic [3:0] d);
        BTN_CHANGE_FLAG   = 1'b1;
        WHICH_BTN_POSEDGE = b;
        SW_DIGIT          = d;
        @(negedge CLK);
        BTN_CHANGE_FLAG   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) ev(B_OK, c[i*4 +: 4]);
    endtask

    initial begin
        idle(2);
        RESET = 1'b0;
        chk_en = 1'b1;
        pin("reset_state", {29'd0, STATE}, 32'd0);
        pin("reset_entry", {16'd0, ENTRY}, 32'd0);

        // Correct code, one CHECK cycle, then 5-cycle auto-relock.
        code(16'h1234);
        pin("check_state", {29'd0, STATE}, 32'd1);
        pin("check_entry", {16'd0, ENTRY}, 32'h1234);
        idle(1);
        pin("unlock_hi", {31'd0, UNLOCK}, 32'd1);
        idle(4);
        pin("unlock_last", {31'd0, UNLOCK}, 32'd1);
        idle(1);
        pin("relock", {31'd0, UNLOCK}, 32'd0);

        // Backspace edit, then backspace on empty buffer.
        ev(B_OK, 4'd1); ev(B_OK, 4'd2); ev(B_OK, 4'd9); ev(B_BS, 4'd0);
        pin("bs_entry", {16'd0, ENTRY}, 32'h12);
        ev(B_OK, 4'd3); ev(B_OK, 4'd4);
        pin("bs_full", {16'd0, ENTRY}, 32'h1234);
        idle(1);
        pin("bs_unlock", {31'd0, UNLOCK}, 32'd1);
        ev(B_RST, 4'd0);
        ev(B_BS, 4'd0);
        pin("bs_empty", {29'd0, DIGIT_CNT}, 32'd0);

        // Three wrong codes lead to an 8-cycle lockout that ignores events.
        code(16'h0000); idle(1);
        pin("err1", {30'd0, ERR_CNT}, 32'd1);
        code(16'h0000); idle(1);
        pin("err2", {30'd0, ERR_CNT}, 32'd2);
        code(16'h0000); idle(1);
        pin("alarm", {31'd0, ALARM}, 32'd1);
        for (int i = 0; i < 7; i++) ev(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        pin("alarm_last", {31'd0, ALARM}, 32'd1);
        idle(1);
        pin("alarm_off", {29'd0, STATE}, 32'd0);

        // Password change to 5678.
        code(16'h1234); idle(1);
        ev(B_ADM, 4'd0);
        pin("set_state", {29'd0, STATE}, 32'd3);
        code(16'h5678);
        pin("set_done", {29'd0, STATE}, 32'd0);
        code(16'h1234); idle(1);
        pin("old_pwd_fails", {31'd0, UNLOCK}, 32'd0);
        code(16'h5678); idle(1);
        pin("new_pwd_ok", {31'd0, UNLOCK}, 32'd1);

        // Reset mid-SET together with an event restores the default password.
        ev(B_ADM, 4'd0); ev(B_OK, 4'd9); ev(B_OK, 4'd9);
        RESET = 1'b1;
        ev(B_OK, 4'd9);
        RESET = 1'b0;
        pin("rst_set_cnt", {29'd0, DIGIT_CNT}, 32'd0);
        code(16'h1234); idle(1);
        pin("rst_pwd_default", {31'd0, UNLOCK}, 32'd1);

        // Random traffic; digits often follow the current password.
        for (int n = 0; n < 3000; n++) begin
            int r, u;
            r = $urandom_range(0, 99);
            u = $urandom_range(0, 9);
            RESET = (r < 2);
            BTN_CHANGE_FLAG = (r >= 2 && r < 65);
            WHICH_BTN_POSEDGE = (u == 0) ? B_RST : (u == 1) ? B_ADM : (u < 4) ? B_BS : B_OK;
            if ($urandom_range(0, 1) == 1 && m_q.size() < 4)
                SW_DIGIT = 4'((m_pwd >> (4 * (3 - m_q.size()))) & 'hF);
            else
                SW_DIGIT = 4'($urandom_range(0, 15));
            @(negedge CLK);
        end
        RESET = 1'b0;
        BTN_CHANGE_FLAG = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
